keypad_entry: RTL and testbench
===============================

# keypad_entry

Upstream keypad front end for the vending machine controller. Turns debounced key events into a three-digit snack selection and presents it to the controller on `valid_input` with the `keypad_ready_signal` / `keypad_wait` handshake. Honours the controller's `clear_keypad` request and locks out entry while a vend is in progress.

## Interface
- `TIMEOUT_CYCLES`, default 500_000_000: idle cycles after the last accepted key before a partial entry is discarded; 0 disables the timeout.
- `TO_W`, default 29: width of the timeout counter; must satisfy 2^TO_W > `TIMEOUT_CYCLES`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_pressed`  in  1  debounced key-down level.
- `key_code`  in  4  key identity, valid while `key_pressed`=1: 0–9 digit, 0xA cancel, 0xB enter, 0xC–0xF ignored.
- `keypad_wait`  in  1  controller busy or accepted; level.
- `clear_keypad`  in  1  controller request to discard the partial entry; level.
- `valid_input`  out  12  entered digits: [3:0] first key (hundreds), [7:4] second, [11:8] third.
- `keypad_ready_signal`  out  1  complete selection available.
- `digit_count`  out  2  digits currently buffered (0–3), for the display.
- `entry_error`  out  1  one-cycle pulse: enter was pressed with fewer than 3 digits, or the entry timed out.

## Operation
- Reset (`reset`=0, asynchronous): state IDLE, `valid_input`=0, `keypad_ready_signal`=0, `digit_count`=0, `entry_error`=0, timeout counter 0, and the key-edge register is cleared.
- A key event is the registered rising edge of `key_pressed`. `key_code` is sampled in that cycle; holding a key produces one event only.
- States:
  - IDLE: no digits buffered.
    - Digit: store it in [3:0], count=1, go to ENTRY.
    - Cancel, enter, 0xC–0xF: ignored.
  - ENTRY: 1–3 digits buffered.
    - Digit with count<3: store in the next nibble and increment count.
    - Digit with count=3: ignored.
    - Cancel: clear the buffer and go to IDLE.
    - Enter with count=3: go to READY.
    - Enter with count<3: clear the buffer, pulse `entry_error`, go to IDLE.
  - READY: `keypad_ready_signal`=1 and `valid_input` held stable.
    - All keys are ignored.
    - `keypad_wait`=1: go to BUSY.
  - BUSY: `keypad_ready_signal`=0 and `valid_input` still held. All keys are ignored.
    - `keypad_wait`=0: clear the buffer and go to IDLE.
- `clear_keypad`=1 in IDLE, ENTRY or READY: clear the buffer, go to IDLE, no error pulse. It takes priority over a same-cycle key event, which is dropped. It is ignored in BUSY.
- `keypad_wait`=1 in IDLE or ENTRY (return-all path): clear the buffer and go to BUSY. This takes priority over `clear_keypad` and over key events.
- In READY, `keypad_wait` takes priority over `clear_keypad`.
- Timeout: the counter runs only in ENTRY and is reset by every accepted key event. On reaching `TIMEOUT_CYCLES`: clear the buffer, pulse `entry_error`, go to IDLE. The counter saturates and never wraps.
- Unused nibbles of `valid_input` read 0.

## Timing
- `key_pressed` rises before edge N. The edge is registered at N, and the buffer, count and state update at N+1. Key-to-`digit_count` latency is 2 cycles.
- Enter accepted at edge E: `keypad_ready_signal` is high from E+1.
- The controller raises `keypad_wait` one edge later. `keypad_ready_signal` falls on the following edge and is never high in the same cycle as the BUSY state.
- `valid_input` does not change between the entry to READY and the exit from BUSY.
- `keypad_wait` fall seen at edge F: `digit_count`=0 and `valid_input`=0 from F+1. A key edge registered at F+1 or later is accepted.
- `entry_error` is exactly one cycle wide.
- Reset asserted mid-entry or mid-handshake clears everything immediately, asynchronously. Release is sampled on the next `clk` edge.

## Test plan
- Keys 1,2,3 then enter (0xB) → `digit_count` goes 1,2,3. `valid_input`=12'h321, `keypad_ready_signal`=1. Raise `keypad_wait` → ready falls next edge. Drop `keypad_wait` → `valid_input`=0, `digit_count`=0.
- Keys 4,5 then enter → one-cycle `entry_error`, state IDLE, `keypad_ready_signal` never asserted.
- Keys 7,8,9,6 then enter → fourth digit ignored, `valid_input`=12'h987. Hold key 3 for 50 cycles during ENTRY → only one digit is added.
- During ENTRY with 2 digits, assert `clear_keypad` in the same cycle as a digit edge → `digit_count`=0, digit dropped, no error pulse. In BUSY, assert `clear_keypad` → `valid_input` is unchanged.
- `TIMEOUT_CYCLES`=20: key 5, then 20 idle cycles → `entry_error` pulse and `digit_count`=0. With a key every 15 cycles → no timeout.
- Pull `reset` low asynchronously while in READY with 12'h321 → `valid_input`=0 and `keypad_ready_signal`=0 before the next `clk` edge. `keypad_wait`=1 while in ENTRY → buffer cleared, BUSY entered, subsequent keys ignored.

Source files
------------

// File: rtl/keypad_entry.sv
// ==========================================================================
// keypad_entry: debounced key events -> 3-digit selection, ready/wait handshake
// Revision: 1.0
// ==========================================================================
`default_nettype none

module keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned TO_W           = 29
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_pressed,
  input  logic [3:0]  key_code,
  input  logic        keypad_wait,
  input  logic        clear_keypad,
  output logic [11:0] valid_input,
  output logic        keypad_ready_signal,
  output logic [1:0]  digit_count,
  output logic        entry_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    READY = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic             key_q, key_ev;
  logic [3:0]       key_val;
  logic [11:0]      buf_nx;
  logic [1:0]       cnt_nx;
  logic             err_nx;
  logic [TO_W-1:0]  to_cnt, to_nx;
  logic             is_digit, timeout_hit;

  assign is_digit            = (key_val <= 4'd9);
  assign timeout_hit         = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign keypad_ready_signal = (state == READY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q       <= 1'b0;
      key_ev      <= 1'b0;
      key_val     <= 4'd0;
      state       <= IDLE;
      valid_input <= 12'd0;
      digit_count <= 2'd0;
      entry_error <= 1'b0;
      to_cnt      <= '0;
    end else begin
      key_q       <= key_pressed;
      key_ev      <= key_pressed & ~key_q;
      key_val     <= key_code;
      state       <= state_nx;
      valid_input <= buf_nx;
      digit_count <= cnt_nx;
      entry_error <= err_nx;
      to_cnt      <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    buf_nx   = valid_input;
    cnt_nx   = digit_count;
    err_nx   = 1'b0;
    to_nx    = '0;
    case (state)
      IDLE, ENTRY: begin
        // Return-all from the controller outranks a clear, which outranks keys.
        if (keypad_wait) begin
          state_nx = BUSY;
          buf_nx   = 12'd0;
          cnt_nx   = 2'd0;
        end else if (clear_keypad) begin
          state_nx = IDLE;
          buf_nx   = 12'd0;
          cnt_nx   = 2'd0;
        end else if (state == IDLE) begin
          if (key_ev && is_digit) begin
            state_nx = ENTRY;
            buf_nx   = {8'd0, key_val};
            cnt_nx   = 2'd1;
          end
        end else if (key_ev) begin
          if (is_digit && digit_count != 2'd3) begin
            if (digit_count == 2'd1) buf_nx[7:4]  = key_val;
            else                     buf_nx[11:8] = key_val;
            cnt_nx = digit_count + 2'd1;
          end else if (key_val == 4'hA) begin
            state_nx = IDLE;
            buf_nx   = 12'd0;
            cnt_nx   = 2'd0;
          end else if (key_val == 4'hB) begin
            if (digit_count == 2'd3) begin
              state_nx = READY;
            end else begin
              state_nx = IDLE;
              buf_nx   = 12'd0;
              cnt_nx   = 2'd0;
              err_nx   = 1'b1;
            end
          end
        end else if (timeout_hit) begin
          state_nx = IDLE;
          buf_nx   = 12'd0;
          cnt_nx   = 2'd0;
          err_nx   = 1'b1;
        end else begin
          to_nx = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
        end
      end
      READY: begin
        if (keypad_wait) begin
          state_nx = BUSY;
        end else if (clear_keypad) begin
          state_nx = IDLE;
          buf_nx   = 12'd0;
          cnt_nx   = 2'd0;
        end
      end
      BUSY: begin
        if (!keypad_wait) begin
          state_nx = IDLE;
          buf_nx   = 12'd0;
          cnt_nx   = 2'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ==========================================================================
// tb_keypad_entry: scoreboard-driven bench for keypad_entry
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_pressed = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        keypad_wait = 1'b0;
  logic        clear_keypad = 1'b0;
  logic [11:0] valid_input, valid_input_t;
  logic        ready, ready_t;
  logic [1:0]  digit_count, digit_count_t;
  logic        entry_error, entry_error_t;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int err_to_seen = 0;
  logic ready_prev = 1'b0;
  logic err_prev = 1'b0;
  logic err_t_prev = 1'b0;
  logic [11:0] exp_sel;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_entry #(.TIMEOUT_CYCLES(1000), .TO_W(10)) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .key_code(key_code),
    .keypad_wait(keypad_wait), .clear_keypad(clear_keypad),
    .valid_input(valid_input), .keypad_ready_signal(ready),
    .digit_count(digit_count), .entry_error(entry_error)
  );

  keypad_entry #(.TIMEOUT_CYCLES(20), .TO_W(5)) dut_to (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .key_code(key_code),
    .keypad_wait(keypad_wait), .clear_keypad(clear_keypad),
    .valid_input(valid_input_t), .keypad_ready_signal(ready_t),
    .digit_count(digit_count_t), .entry_error(entry_error_t)
  );

  // Scoreboard: every rising ready must match the oldest pushed selection.
  always @(negedge clk) begin
    if (reset && ready && !ready_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sel_unexpected ready rose with valid_input=%h, none expected", valid_input);
      end else begin
        exp_sel = exp_q.pop_front();
        if (valid_input !== exp_sel) begin
          bad++;
          $display("FAIL sel_value got=%h want=%h", valid_input, exp_sel);
        end
      end
    end
    if (entry_error) begin
      err_seen++;
      total++;
      if (err_prev) begin
        bad++;
        $display("FAIL err_width entry_error high two cycles got=1 want=0");
      end
    end
    if (entry_error_t) begin
      err_to_seen++;
      total++;
      if (err_t_prev) begin
        bad++;
        $display("FAIL err_t_width entry_error high two cycles got=1 want=0");
      end
    end
    ready_prev = ready;
    err_prev   = entry_error;
    err_t_prev = entry_error_t;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c);
    key_code = c;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic handshake();
    keypad_wait = 1'b1;
    @(negedge clk);
    keypad_wait = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick(2);
    total++; if (valid_input !== 12'd0) begin bad++; $display("FAIL rst_valid got=%h want=000", valid_input); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", digit_count); end
    total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", entry_error); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    press(4'd1);
    total++; if (digit_count !== 2'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d want=1", digit_count); end
    press(4'd2);
    total++; if (digit_count !== 2'd2) begin bad++; $display("FAIL basic_cnt2 got=%0d want=2", digit_count); end
    press(4'd3);
    total++; if (digit_count !== 2'd3) begin bad++; $display("FAIL basic_cnt3 got=%0d want=3", digit_count); end
    exp_q.push_back(12'h321);
    press(4'hB);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", ready); end
    keypad_wait = 1'b1;
    tick(1);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_fall got=%b want=0", ready); end
    total++; if (valid_input !== 12'h321) begin bad++; $display("FAIL basic_busy_hold got=%h want=321", valid_input); end
    keypad_wait = 1'b0;
    tick(1);
    total++; if (valid_input !== 12'd0) begin bad++; $display("FAIL basic_release_valid got=%h want=000", valid_input); end
    total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL basic_release_cnt got=%0d want=0", digit_count); end
  endtask

  task automatic test_short_entry();
    int e0;
    e0 = err_seen;
    press(4'd4);
    press(4'd5);
    press(4'hB);
    total++; if (entry_error !== 1'b1) begin bad++; $display("FAIL short_err got=%b want=1", entry_error); end
    total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL short_cnt got=%0d want=0", digit_count); end
    tick(1);
    total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL short_err_fall got=%b want=0", entry_error); end
    total++; if (err_seen - e0 !== 1) begin bad++; $display("FAIL short_err_count got=%0d want=1", err_seen - e0); end
  endtask

  task automatic test_extra_digit();
    press(4'd7); press(4'd8); press(4'd9); press(4'd6);
    total++; if (digit_count !== 2'd3) begin bad++; $display("FAIL extra_cnt got=%0d want=3", digit_count); end
    total++; if (valid_input !== 12'h987) begin bad++; $display("FAIL extra_valid got=%h want=987", valid_input); end
    exp_q.push_back(12'h987);
    press(4'hB);
    handshake();
    press(4'd7);
    key_code = 4'd3;
    key_pressed = 1'b1;
    tick(50);
    key_pressed = 1'b0;
    tick(1);
    total++; if (digit_count !== 2'd2) begin bad++; $display("FAIL hold_cnt got=%0d want=2", digit_count); end
    total++; if (valid_input !== 12'h037) begin bad++; $display("FAIL hold_valid got=%h want=037", valid_input); end
    press(4'hA);
    total++; if (valid_input !== 12'd0 || digit_count !== 2'd0) begin bad++; $display("FAIL cancel got=%h/%0d want=000/0", valid_input, digit_count); end
  endtask

  task automatic test_clear();
    int e0;
    e0 = err_seen;
    press(4'd1);
    press(4'd2);
    key_code = 4'd4;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    clear_keypad = 1'b1;
    @(negedge clk);
    clear_keypad = 1'b0;
    total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL clear_cnt got=%0d want=0", digit_count); end
    total++; if (valid_input !== 12'd0) begin bad++; $display("FAIL clear_valid got=%h want=000", valid_input); end
    tick(2);
    total++; if (err_seen != e0) begin bad++; $display("FAIL clear_err got=%0d want=0", err_seen - e0); end
    press(4'd1); press(4'd2); press(4'd3);
    exp_q.push_back(12'h321);
    press(4'hB);
    keypad_wait = 1'b1;
    tick(1);
    clear_keypad = 1'b1;
    tick(3);
    total++; if (valid_input !== 12'h321) begin bad++; $display("FAIL busy_clear_valid got=%h want=321", valid_input); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_clear_ready got=%b want=0", ready); end
    clear_keypad = 1'b0;
    keypad_wait = 1'b0;
    tick(1);
    total++; if (valid_input !== 12'd0) begin bad++; $display("FAIL busy_exit_valid got=%h want=000", valid_input); end
  endtask

  task automatic test_timeout();
    int at;
    int e0;
    bit found;
    press(4'd5);
    found = 1'b0;
    at = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (entry_error_t) begin
        found = 1'b1;
        at = i;
      end
    end
    total++; if (!found || at < 19 || at > 21) begin bad++; $display("FAIL timeout_at got=%0d want=20", at); end
    total++; if (digit_count_t !== 2'd0) begin bad++; $display("FAIL timeout_cnt got=%0d want=0", digit_count_t); end
    press(4'hA);
    e0 = err_to_seen;
    press(4'd1); tick(13);
    press(4'd2); tick(13);
    press(4'd3); tick(13);
    total++; if (err_to_seen != e0) begin bad++; $display("FAIL no_timeout_err got=%0d want=0", err_to_seen - e0); end
    total++; if (digit_count_t !== 2'd3) begin bad++; $display("FAIL no_timeout_cnt got=%0d want=3", digit_count_t); end
    press(4'hA);
  endtask

  task automatic test_async_reset();
    press(4'd1); press(4'd2); press(4'd3);
    exp_q.push_back(12'h321);
    press(4'hB);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (valid_input !== 12'd0) begin bad++; $display("FAIL areset_valid got=%h want=000", valid_input); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL areset_ready got=%b want=0", ready); end
    @(negedge clk);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_wait_in_entry();
    press(4'd1);
    press(4'd2);
    keypad_wait = 1'b1;
    tick(1);
    total++; if (digit_count !== 2'd0 || valid_input !== 12'd0) begin bad++; $display("FAIL wait_entry got=%h/%0d want=000/0", valid_input, digit_count); end
    press(4'd3);
    total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL wait_busy_key got=%0d want=0", digit_count); end
    keypad_wait = 1'b0;
    tick(1);
    press(4'd6);
    total++; if (digit_count !== 2'd1 || valid_input !== 12'h006) begin bad++; $display("FAIL wait_after got=%h/%0d want=006/1", valid_input, digit_count); end
    press(4'hA);
  endtask

  task automatic test_back_to_back();
    logic [3:0] d[3];
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) d[k] = 4'($urandom_range(0, 9));
      exp_q.push_back({d[2], d[1], d[0]});
      for (int k = 0; k < 3; k++) press(d[k]);
      press(4'hB);
      handshake();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_entry();
    test_extra_digit();
    test_clear();
    test_timeout();
    test_async_reset();
    test_wait_in_entry();
    test_back_to_back();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
